// File: rtl/score4_pkg.sv
// Shared types for the score4 match controller: FSM encoding and player ids.
package score4_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SYNC       = 3'd1,
    CLEAR      = 3'd2,
    PLAY       = 3'd3,
    RESULT     = 3'd4,
    MATCH_OVER = 3'd5
  } match_state_t;

  localparam logic PLAYER_A = 1'b0;
  localparam logic PLAYER_B = 1'b1;

endpackage

// File: rtl/match_sequencer_if.sv
// Core/peer status inputs and match control/score outputs of the match sequencer.
interface match_sequencer_if #(
  parameter int unsigned SCORE_W = 4
);
  logic               start;
  logic               peer_ready;
  logic               move_done;
  logic               player;
  logic               win_a;
  logic               win_b;
  logic               full_panel;
  logic               local_ready;
  logic               core_clear;
  logic               core_enable;
  logic               first_player;
  logic [SCORE_W-1:0] score_a;
  logic [SCORE_W-1:0] score_b;
  logic               forfeit;
  logic               match_over;
  logic [2:0]         state;

  modport slave (
    input  start, peer_ready, move_done, player, win_a, win_b, full_panel,
    output local_ready, core_clear, core_enable, first_player,
           score_a, score_b, forfeit, match_over, state
  );

  modport master (
    output start, peer_ready, move_done, player, win_a, win_b, full_panel,
    input  local_ready, core_clear, core_enable, first_player,
           score_a, score_b, forfeit, match_over, state
  );
endinterface

// File: rtl/match_sequencer_cycle_timer.sv
// Up-counter from 0 with terminal-count flag at LIMIT-1; load wins over enable.
module cycle_timer #(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic tc
);
  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign tc = (count_q == LAST);

  // Parks at the terminal count so an idle enable can never wrap the counter.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (enable && !tc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/match_sequencer.sv
// Round/match controller in front of the score4 core: peer sync, core clear,
// timed play, result hold, and per-player round scores up to MATCH_POINTS.
module match_sequencer
  import score4_pkg::*;
#(
  parameter int unsigned TURN_TIMEOUT = 250_000_000,
  parameter int unsigned RESULT_HOLD  = 100_000_000,
  parameter int unsigned MATCH_POINTS = 3,
  parameter int unsigned SCORE_W      = 4
) (
  input logic               clk,
  input logic               rst,
  match_sequencer_if.slave  bus
);
  localparam logic [SCORE_W-1:0] MP = SCORE_W'(MATCH_POINTS);

  match_state_t       state_q, state_d;
  logic               core_clear_q, core_clear_d;
  logic               core_enable_q, core_enable_d;
  logic               first_player_q, first_player_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d;
  logic [SCORE_W-1:0] score_b_q, score_b_d;
  logic               forfeit_q, forfeit_d;
  logic               match_over_q, match_over_d;

  logic turn_load, turn_en, turn_tc;
  logic hold_load, hold_en, hold_tc;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s < MP) ? s + 1'b1 : s;
  endfunction

  assign turn_load = (state_q == CLEAR) || ((state_q == PLAY) && bus.move_done);
  assign turn_en   = (state_q == PLAY);
  assign hold_load = (state_q != RESULT);
  assign hold_en   = (state_q == RESULT);

  cycle_timer #(.LIMIT(TURN_TIMEOUT)) u_turn_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (turn_load),
    .enable (turn_en),
    .tc     (turn_tc)
  );

  cycle_timer #(.LIMIT(RESULT_HOLD)) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (hold_load),
    .enable (hold_en),
    .tc     (hold_tc)
  );

  always_comb begin
    state_d        = state_q;
    first_player_d = first_player_q;
    score_a_d      = score_a_q;
    score_b_d      = score_b_q;
    forfeit_d      = forfeit_q;

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = SYNC;
      end
      SYNC: begin
        if (bus.start)           state_d = IDLE;
        else if (bus.peer_ready) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = PLAY;
      end
      PLAY: begin
        // A move landing on the timeout cycle counts as a move, not a forfeit.
        if (bus.win_a && bus.win_b) begin
          state_d = RESULT;
        end else if (bus.win_a) begin
          score_a_d = sat_inc(score_a_q);
          state_d   = RESULT;
        end else if (bus.win_b) begin
          score_b_d = sat_inc(score_b_q);
          state_d   = RESULT;
        end else if (bus.full_panel) begin
          state_d = RESULT;
        end else if (turn_tc && !bus.move_done) begin
          forfeit_d = 1'b1;
          if (bus.player == PLAYER_A) score_b_d = sat_inc(score_b_q);
          else                        score_a_d = sat_inc(score_a_q);
          state_d = RESULT;
        end
      end
      RESULT: begin
        if ((score_a_q == MP) || (score_b_q == MP)) begin
          state_d = MATCH_OVER;
        end else if (hold_tc) begin
          first_player_d = ~first_player_q;
          state_d        = SYNC;
        end
      end
      MATCH_OVER: begin
        if (bus.start) begin
          score_a_d      = '0;
          score_b_d      = '0;
          first_player_d = PLAYER_A;
          state_d        = SYNC;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == CLEAR) forfeit_d = 1'b0;

    core_clear_d  = (state_d == CLEAR);
    core_enable_d = (state_d == PLAY);
    match_over_d  = (state_d == MATCH_OVER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      core_clear_q   <= 1'b0;
      core_enable_q  <= 1'b0;
      first_player_q <= PLAYER_A;
      score_a_q      <= '0;
      score_b_q      <= '0;
      forfeit_q      <= 1'b0;
      match_over_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      core_clear_q   <= core_clear_d;
      core_enable_q  <= core_enable_d;
      first_player_q <= first_player_d;
      score_a_q      <= score_a_d;
      score_b_q      <= score_b_d;
      forfeit_q      <= forfeit_d;
      match_over_q   <= match_over_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.local_ready  = (state_q == SYNC);
  assign bus.core_clear   = core_clear_q;
  assign bus.core_enable  = core_enable_q;
  assign bus.first_player = first_player_q;
  assign bus.score_a      = score_a_q;
  assign bus.score_b      = score_b_q;
  assign bus.forfeit      = forfeit_q;
  assign bus.match_over   = match_over_q;
endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer: stimulus queues expected output snapshots,
// a negedge monitor pops and compares them against the DUT.
module tb_match_sequencer;
  localparam int unsigned TT = 20;
  localparam int unsigned RH = 8;
  localparam int unsigned MPTS = 2;
  localparam int unsigned SW = 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_CLR  = 3'd2;
  localparam logic [2:0] S_PLAY = 3'd3;
  localparam logic [2:0] S_RES  = 3'd4;
  localparam logic [2:0] S_MO   = 3'd5;

  typedef struct {
    string       name;
    logic [16:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  match_sequencer_if #(.SCORE_W(SW)) bus ();

  match_sequencer #(
    .TURN_TIMEOUT (TT),
    .RESULT_HOLD  (RH),
    .MATCH_POINTS (MPTS),
    .SCORE_W      (SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Layout: state, local_ready, core_clear, core_enable, first_player, forfeit, match_over, score_a, score_b
  function automatic logic [16:0] actual();
    return {bus.state, bus.local_ready, bus.core_clear, bus.core_enable,
            bus.first_player, bus.forfeit, bus.match_over, bus.score_a, bus.score_b};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [16:0] a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = actual();
      checks++;
      if (a !== e.v) begin
        errors++;
        $display("FAIL %s: got st=%0d lr=%b cc=%b ce=%b fp=%b ff=%b mo=%b sa=%0d sb=%0d, expected st=%0d lr=%b cc=%b ce=%b fp=%b ff=%b mo=%b sa=%0d sb=%0d",
                 e.name, a[16:14], a[13], a[12], a[11], a[10], a[9], a[8], a[7:4], a[3:0],
                 e.v[16:14], e.v[13], e.v[12], e.v[11], e.v[10], e.v[9], e.v[8], e.v[7:4], e.v[3:0]);
      end
    end
  end

  task automatic chk(input string name, input logic [2:0] st, input logic cc, input logic ce,
                     input logic fp, input logic ff, input logic mo,
                     input logic [3:0] sa, input logic [3:0] sb);
    exp_t e;
    e.name = name;
    e.v    = {st, (st == S_SYNC), cc, ce, fp, ff, mo, sa, sb};
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic enter_play();
    bus.peer_ready = 1'b1;
    step(1);
    bus.peer_ready = 1'b0;
    step(1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start      = 1'b0;
    bus.peer_ready = 1'b0;
    bus.move_done  = 1'b0;
    bus.player     = 1'b0;
    bus.win_a      = 1'b0;
    bus.win_b      = 1'b0;
    bus.full_panel = 1'b0;

    step(2);
    chk("reset", S_IDLE, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    bus.peer_ready = 1'b1;
    step(1);
    bus.peer_ready = 1'b0;
    chk("idle_ignores_peer", S_IDLE, 0, 0, 0, 0, 0, 0, 0);

    bus.start = 1'b1; step(1); bus.start = 1'b0;
    chk("start_to_sync", S_SYNC, 0, 0, 0, 0, 0, 0, 0);
    bus.start = 1'b1; step(1); bus.start = 1'b0;
    chk("sync_abort", S_IDLE, 0, 0, 0, 0, 0, 0, 0);
    bus.start = 1'b1; step(1); bus.start = 1'b0;
    chk("sync_again", S_SYNC, 0, 0, 0, 0, 0, 0, 0);
    step(1);
    chk("sync_wait_peer", S_SYNC, 0, 0, 0, 0, 0, 0, 0);
    bus.peer_ready = 1'b1; step(1); bus.peer_ready = 1'b0;
    chk("clear_pulse", S_CLR, 1, 0, 0, 0, 0, 0, 0);
    step(1);
    chk("play_r1", S_PLAY, 0, 1, 0, 0, 0, 0, 0);

    step(3);
    bus.win_a = 1'b1; step(1); bus.win_a = 1'b0;
    chk("win_a_r1", S_RES, 0, 0, 0, 0, 0, 1, 0);
    step(RH - 1);
    chk("hold_last_cycle", S_RES, 0, 0, 0, 0, 0, 1, 0);
    step(1);
    chk("next_round_fp", S_SYNC, 0, 0, 1, 0, 0, 1, 0);

    enter_play();
    chk("play_r2", S_PLAY, 0, 1, 1, 0, 0, 1, 0);
    bus.win_a = 1'b1; bus.win_b = 1'b1; step(1); bus.win_a = 1'b0; bus.win_b = 1'b0;
    chk("draw_both_wins", S_RES, 0, 0, 1, 0, 0, 1, 0);
    step(RH);
    chk("sync_r3", S_SYNC, 0, 0, 0, 0, 0, 1, 0);

    enter_play();
    bus.full_panel = 1'b1; bus.win_b = 1'b1; step(1); bus.full_panel = 1'b0; bus.win_b = 1'b0;
    chk("panel_with_win_b", S_RES, 0, 0, 0, 0, 0, 1, 1);
    step(RH);
    chk("sync_r4", S_SYNC, 0, 0, 1, 0, 0, 1, 1);

    enter_play();
    bus.win_a = 1'b1; step(1); bus.win_a = 1'b0;
    chk("match_point", S_RES, 0, 0, 1, 0, 0, 2, 1);
    step(1);
    chk("match_over", S_MO, 0, 0, 1, 0, 1, 2, 1);
    bus.win_a = 1'b1; bus.move_done = 1'b1; step(3); bus.win_a = 1'b0; bus.move_done = 1'b0;
    chk("scores_frozen", S_MO, 0, 0, 1, 0, 1, 2, 1);
    bus.start = 1'b1; step(1); bus.start = 1'b0;
    chk("new_match", S_SYNC, 0, 0, 0, 0, 0, 0, 0);

    enter_play();
    chk("play_m2", S_PLAY, 0, 1, 0, 0, 0, 0, 0);
    bus.player = 1'b1;
    step(TT - 1);
    bus.move_done = 1'b1; step(1); bus.move_done = 1'b0;
    chk("move_on_timeout_cycle", S_PLAY, 0, 1, 0, 0, 0, 0, 0);
    step(TT - 1);
    chk("before_timeout", S_PLAY, 0, 1, 0, 0, 0, 0, 0);
    step(1);
    chk("timeout_player_b", S_RES, 0, 0, 0, 1, 0, 1, 0);
    step(RH);
    chk("sync_keeps_forfeit", S_SYNC, 0, 0, 1, 1, 0, 1, 0);
    bus.peer_ready = 1'b1; step(1); bus.peer_ready = 1'b0;
    chk("clear_drops_forfeit", S_CLR, 1, 0, 1, 0, 0, 1, 0);
    step(1);
    bus.player = 1'b0;
    step(TT - 1);
    chk("r2_before_timeout", S_PLAY, 0, 1, 1, 0, 0, 1, 0);
    step(1);
    chk("timeout_player_a", S_RES, 0, 0, 1, 1, 0, 1, 1);
    step(RH);
    chk("sync_m2r3", S_SYNC, 0, 0, 0, 1, 0, 1, 1);

    enter_play();
    chk("play_m2r3", S_PLAY, 0, 1, 0, 0, 0, 1, 1);
    step(2);
    rst = 1'b0;
    chk("async_reset", S_IDLE, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    step(1);
    chk("reset_held", S_IDLE, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_checks: got %0d unchecked, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
